synaptic_accumulator: RTL and testbench

Parametrised, lane-sliced synaptic current accumulator for the Izhikevich graph accelerator. It dequeues fired-neuron tags from the spike FIFO, reads that neuron's efferent weight row LANES words per cycle, and saturating-adds the row into the next-step current vector `i_next`. On a swap request it publishes `i_next` to the current vector `i` and decays `i_next` by an arithmetic right shift. It sits between the spike FIFO and the neuron update engine, which reads `i` by tag.

---
 rtl/synacc_pkg.sv | 18 +
 rtl/synaptic_accumulator_sat_adder_lane.sv | 12 +
 rtl/synaptic_accumulator.sv | 104 ++++++++++
 tb/tb_synaptic_accumulator.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/synacc_pkg.sv
// synacc_pkg: shared FSM state, chunk-count helper and width-generic saturating add
package synacc_pkg;
   typedef enum logic [1:0] {IDLE, ACCUM, SWAP} state_t;
   localparam int SAT_W = 64;
   function automatic int chunks(input int n, input int l);
      return n / l;
   endfunction
   // Operands arrive sign-extended to SAT_W, so the wide sum never wraps before clamping to w bits
   function automatic logic signed [SAT_W-1:0] sat_add(input logic signed [SAT_W-1:0] a,
                                                       input logic signed [SAT_W-1:0] b,
                                                       input int w);
      logic signed [SAT_W-1:0] s, hi, lo;
      s = a + b;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      return (s > hi) ? hi : (s < lo) ? lo : s;
   endfunction
endpackage

// File: rtl/synaptic_accumulator_sat_adder_lane.sv
// sat_adder_lane: one signed saturating adder of NUM_W bits
module sat_adder_lane
   import synacc_pkg::*;
#(
   parameter int NUM_W = 17
) (
   input  logic signed [NUM_W-1:0] a,
   input  logic signed [NUM_W-1:0] b,
   output logic signed [NUM_W-1:0] y
);
   assign y = NUM_W'(sat_add(SAT_W'(a), SAT_W'(b), NUM_W));
endmodule

// File: rtl/synaptic_accumulator.sv
// synaptic_accumulator: adds fired neurons' weight rows into i_next, LANES words per cycle,
// and publishes i_next to i (with decay) on swap
module synaptic_accumulator
   import synacc_pkg::*;
#(
   parameter int NUM_W       = 17,
   parameter int TAG_BITS    = 7,
   parameter int NUM_NEURONS = 128,
   parameter int LANES       = 16,
   parameter int DECAY_SHIFT = 1
) (
   input  logic                       clk,
   input  logic                       asyn_reset,
   input  logic                       fifo_empty,
   input  logic [TAG_BITS-1:0]        fired_tag,
   output logic                       req_deq,
   input  logic                       swap,
   output logic                       busy,
   output logic                       swap_done,
   input  logic                       wr_en,
   input  logic [TAG_BITS-1:0]        wr_src,
   input  logic [TAG_BITS-1:0]        wr_dst,
   input  logic signed [NUM_W-1:0]    wr_data,
   input  logic [TAG_BITS-1:0]        i_tag,
   output logic signed [NUM_W-1:0]    i_out
);
   localparam int C  = chunks(NUM_NEURONS, LANES);
   localparam int CW = $clog2(C + 1);
   localparam int NW = $clog2(NUM_NEURONS);
   localparam int AW = $clog2(NUM_NEURONS * C);
   state_t                    state;
   logic [TAG_BITS-1:0]       tag_r;
   logic [CW-1:0]             k, kc;
   logic                      swap_pend;
   logic [LANES*NUM_W-1:0]    mem [NUM_NEURONS*C];
   logic [LANES*NUM_W-1:0]    w_r;
   logic signed [NUM_W-1:0]   i [NUM_NEURONS];
   logic signed [NUM_W-1:0]   i_next [NUM_NEURONS];
   logic signed [NUM_W-1:0]   sum [LANES];
   logic [AW-1:0]             rd_idx, wr_idx;
   int                        wr_lane;
   logic                      wr_ok;
   assign req_deq = state == IDLE && !fifo_empty;
   assign busy    = state != IDLE || swap_pend;
   assign kc      = (k == '0) ? '0 : k - 1'b1;
   assign rd_idx  = AW'(int'(tag_r) * C + int'(k));
   assign wr_idx  = AW'(int'(wr_src) * C + int'(wr_dst) / LANES);
   assign wr_lane = int'(wr_dst) % LANES;
   assign wr_ok   = wr_en && int'(wr_src) < NUM_NEURONS && int'(wr_dst) < NUM_NEURONS;
   // Read and write share one edge, so a colliding read sees the old word
   always_ff @(posedge clk) begin
      w_r <= mem[rd_idx];
      if (wr_ok) mem[wr_idx][wr_lane*NUM_W +: NUM_W] <= wr_data;
   end
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      sat_adder_lane #(.NUM_W(NUM_W)) u_add (
         .a(i_next[NW'(int'(kc) * LANES + l)]),
         .b($signed(w_r[l*NUM_W +: NUM_W])),
         .y(sum[l])
      );
   end
   always_ff @(posedge clk or posedge asyn_reset) begin
      if (asyn_reset) begin
         state     <= IDLE;
         tag_r     <= '0;
         k         <= '0;
         swap_pend <= 1'b0;
         swap_done <= 1'b0;
         i_out     <= '0;
         for (int n = 0; n < NUM_NEURONS; n++) begin
            i[n]      <= '0;
            i_next[n] <= '0;
         end
      end else begin
         swap_pend <= swap || (swap_pend && state != SWAP);
         swap_done <= state == SWAP;
         i_out     <= (int'(i_tag) < NUM_NEURONS) ? i[NW'(i_tag)] : '0;
         case (state)
            IDLE: begin
               if (!fifo_empty) begin
                  tag_r <= fired_tag;
                  k     <= '0;
                  state <= ACCUM;
               end else if (swap_pend) state <= SWAP;
            end
            ACCUM: begin
               k <= k + 1'b1;
               // Out-of-range tags still walk the row timing but never touch i_next
               if (k != '0 && int'(tag_r) < NUM_NEURONS)
                  for (int l = 0; l < LANES; l++) i_next[NW'(int'(kc) * LANES + l)] <= sum[l];
               if (k == CW'(C)) state <= IDLE;
            end
            SWAP: begin
               for (int n = 0; n < NUM_NEURONS; n++) begin
                  i[n]      <= i_next[n];
                  i_next[n] <= i_next[n] >>> DECAY_SHIFT;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_synaptic_accumulator.sv
// tb_synaptic_accumulator: scoreboard bench driving a DECAY_SHIFT=1 and a DECAY_SHIFT=0 instance
module tb_synaptic_accumulator;
   localparam int W = 17, TB = 7, NN = 8, LN = 4;
   localparam int MX = 2 ** (W - 1) - 1;
   logic clk = 0, asyn_reset = 0, fifo_empty = 1, swap = 0, wr_en = 0;
   logic [TB-1:0] fired_tag = '0, wr_src = '0, wr_dst = '0, i_tag = '0;
   logic signed [W-1:0] wr_data = '0, i_out, i_out0;
   logic req_deq, busy, swap_done, req_deq0, busy0, swap_done0;
   int n_cmp = 0, n_err = 0, n_deq = 0, n_sd = 0;
   int fq[$];
   logic deq_q = 0, rd_v = 0, rd_d = 0;
   typedef struct {int t; int e1; int e0;} exp_t;
   exp_t exp_q[$];
   exp_t e_pop;
   int wm[NN][NN];
   int inx[NN], iv[NN], inx0[NN], iv0[NN];
   always #5 clk = ~clk;
   synaptic_accumulator #(.NUM_W(W), .TAG_BITS(TB), .NUM_NEURONS(NN), .LANES(LN), .DECAY_SHIFT(1)) dut (
      .clk(clk), .asyn_reset(asyn_reset), .fifo_empty(fifo_empty), .fired_tag(fired_tag),
      .req_deq(req_deq), .swap(swap), .busy(busy), .swap_done(swap_done), .wr_en(wr_en),
      .wr_src(wr_src), .wr_dst(wr_dst), .wr_data(wr_data), .i_tag(i_tag), .i_out(i_out));
   synaptic_accumulator #(.NUM_W(W), .TAG_BITS(TB), .NUM_NEURONS(NN), .LANES(LN), .DECAY_SHIFT(0)) dut0 (
      .clk(clk), .asyn_reset(asyn_reset), .fifo_empty(fifo_empty), .fired_tag(fired_tag),
      .req_deq(req_deq0), .swap(swap), .busy(busy0), .swap_done(swap_done0), .wr_en(wr_en),
      .wr_src(wr_src), .wr_dst(wr_dst), .wr_data(wr_data), .i_tag(i_tag), .i_out(i_out0));
   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   function automatic int sat(input int x);
      return x > MX ? MX : x < -MX - 1 ? -MX - 1 : x;
   endfunction
   task automatic model_spike(input int t);
      if (t < NN)
         for (int d = 0; d < NN; d++) begin
            inx[d]  = sat(inx[d] + wm[t][d]);
            inx0[d] = sat(inx0[d] + wm[t][d]);
         end
   endtask
   task automatic model_swap();
      for (int n = 0; n < NN; n++) begin
         iv[n] = inx[n];
         inx[n] = inx[n] >>> 1;
         iv0[n] = inx0[n];
      end
   endtask
   task automatic model_reset();
      for (int n = 0; n < NN; n++) begin
         inx[n] = 0; iv[n] = 0; inx0[n] = 0; iv0[n] = 0;
      end
   endtask
   // FIFO model: pop the head on the negedge after the edge that dequeued it
   always @(posedge clk) begin
      deq_q <= req_deq;
      rd_d  <= rd_v;
   end
   always @(negedge clk) begin
      if (deq_q) begin
         void'(fq.pop_front());
         n_deq++;
         fifo_empty = fq.size() == 0;
         fired_tag = fifo_empty ? '0 : TB'(fq[0]);
      end
      if (swap_done) n_sd++;
      if (rd_d) begin
         if (exp_q.size() == 0) check("sb_underflow", 1, 0);
         else begin
            e_pop = exp_q.pop_front();
            check($sformatf("i_out[%0d]", e_pop.t), int'(i_out), e_pop.e1);
            check($sformatf("i_out0[%0d]", e_pop.t), int'(i_out0), e_pop.e0);
         end
      end
   end
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic wr(input int s, input int d, input int v);
      @(negedge clk);
      wr_en = 1; wr_src = TB'(s); wr_dst = TB'(d); wr_data = W'(v);
      if (s < NN && d < NN) wm[s][d] = v;
      @(negedge clk);
      wr_en = 0;
   endtask
   task automatic push(input int t);
      @(negedge clk);
      fq.push_back(t);
      fifo_empty = 0;
      fired_tag = TB'(fq[0]);
      model_spike(t);
   endtask
   task automatic wait_idle();
      int c = 0;
      @(negedge clk);
      while ((busy || !fifo_empty) && c < 100) begin
         @(negedge clk);
         c++;
      end
      if (c >= 100) check("idle_timeout", c, 0);
   endtask
   task automatic do_swap();
      n_sd = 0;
      @(negedge clk) swap = 1;
      @(negedge clk) swap = 0;
      @(negedge clk) check("swap_done_early", int'(swap_done), 0);
      @(negedge clk) check("swap_done", int'(swap_done), 1);
      model_swap();
      tick(2);
      check("swap_done_count", n_sd, 1);
   endtask
   task automatic rd(input int t);
      @(negedge clk);
      i_tag = TB'(t);
      rd_v = 1;
      exp_q.push_back('{t, iv[t], iv0[t]});
      @(negedge clk);
      rd_v = 0;
   endtask
   task automatic rd_all();
      for (int n = 0; n < NN; n++) rd(n);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
   initial begin
      int cnt;
      model_reset();
      #2 asyn_reset = 1;
      tick(3);
      check("req_deq_rst", int'(req_deq), 0);
      check("busy_rst", int'(busy), 0);
      check("swap_done_rst", int'(swap_done), 0);
      check("busy0_rst", int'(busy0), 0);
      check("req_deq0_rst", int'(req_deq0), 0);
      check("swap_done0_rst", int'(swap_done0), 0);
      asyn_reset = 0;
      for (int s = 0; s < NN; s++)
         for (int d = 0; d < NN; d++) wr(s, d, s == 3 ? d + 1 : 0);
      wr(0, 2, 65535);
      wr(1, 2, -65536);
      wr(2, 4, 1);
      wr(4, 0, -5);
      // Reset in the middle of ACCUM
      push(3);
      tick(2);
      check("busy_accum", int'(busy), 1);
      asyn_reset = 1;
      #1;
      check("busy_async_rst", int'(busy), 0);
      check("req_deq_async_rst", int'(req_deq), 0);
      check("swap_done_async_rst", int'(swap_done), 0);
      for (int t = 0; t < NN; t++) begin
         i_tag = TB'(t);
         @(negedge clk);
         check($sformatf("i_out_rst[%0d]", t), int'(i_out), 0);
      end
      asyn_reset = 0;
      model_reset();
      do_swap();
      rd_all();
      // Single spike
      n_deq = 0;
      push(3);
      cnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (busy) cnt++;
         else if (cnt > 0) break;
      end
      check("accum_cycles", cnt, 3);
      wait_idle();
      check("deq_count", n_deq, 1);
      do_swap();
      rd(5);
      do_swap();
      rd(5);
      // Saturation both ways
      push(0);
      push(0);
      wait_idle();
      do_swap();
      rd(2);
      push(1);
      push(1);
      push(1);
      wait_idle();
      do_swap();
      rd(2);
      // Swap requested while tags are queued; second request collapses
      n_sd = 0;
      push(1);
      push(2);
      @(negedge clk) swap = 1;
      @(negedge clk) swap = 0;
      tick(2);
      swap = 1;
      @(negedge clk) swap = 0;
      wait_idle();
      tick(3);
      check("swap_once", n_sd, 1);
      model_swap();
      rd_all();
      // Out-of-range write addresses and fired tag
      wr(0, 12, 77);
      wr(9, 0, 77);
      push(9);
      wait_idle();
      push(1);
      wait_idle();
      do_swap();
      rd_all();
      // Decay rounding of a negative current
      @(negedge clk) asyn_reset = 1;
      @(negedge clk) asyn_reset = 0;
      model_reset();
      push(4);
      wait_idle();
      do_swap();
      rd(0);
      do_swap();
      rd(0);
      // Write to the word being read in the same cycle
      push(2);
      @(negedge clk);
      @(negedge clk);
      wr_en = 1; wr_src = TB'(2); wr_dst = TB'(4); wr_data = W'(9);
      @(negedge clk);
      wr_en = 0;
      wm[2][4] = 9;
      wait_idle();
      do_swap();
      rd(4);
      push(2);
      wait_idle();
      do_swap();
      rd(4);
      tick(3);
      check("sb_drain", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
